multicore_system_ram_copier: RTL and testbench
==============================================

# multicore_system_ram_copier

Avalon-MM master that drives one core's on-chip RAM slave port (10-bit word address, 32-bit data, byte enables, fixed read latency, no waitrequest). On a start command it copies a block of words from a source word address to a destination word address inside the same single-port RAM, one read then one write per word. It is used to seed a core's private RAM, or to move a mailbox region, without involving that core's CPU. An optional running checksum of the copied data is available.

## Interface
Parameters:
- READ_LATENCY, 1: cycles from a read-address cycle to valid readdata. Legal range is 1–3. Use 1 for an unregistered-output RAM.
- ADDR_W, 10: word address width. The RAM depth is 2^ADDR_W.

Ports:
- clk  in  1  system clock. Everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe. Sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address. Latched on an accepted start.
- dst_addr  in  ADDR_W  first destination word address. Latched on an accepted start.
- word_count  in  ADDR_W+1  number of words to copy, 0..2^ADDR_W. Latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the copy completes.
- checksum  out  32  sum of the copied words, modulo 2^32.
- avm_address  out  ADDR_W  RAM word address.
- avm_byteenable  out  4  4'hF whenever avm_chipselect is high, otherwise 4'h0.
- avm_chipselect  out  1  RAM select.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  RAM read data.

## Operation
States:
- IDLE:
  - start=1 with word_count≠0 → READ. Latch src, dst and count; clear the word index and the checksum.
  - start=1 with word_count=0 → DONE. No bus cycle is issued.
- READ: avm_chipselect=1, avm_write=0, avm_address=src+idx. Go to WAIT.
- WAIT: the bus is idle (chipselect=0). Stay READ_LATENCY cycles. On the last WAIT cycle, capture avm_readdata into the data register, then go to WRITE.
- WRITE: avm_chipselect=1, avm_write=1, avm_address=dst+idx, avm_writedata=data register, avm_byteenable=4'hF.
  - idx+1 = count → DONE.
  - otherwise increment idx → READ.
- DONE: done=1 for exactly one cycle, checksum final. Go to IDLE.

Rules:
- Address arithmetic is modulo 2^ADDR_W. src+idx and dst+idx wrap from 1023 to 0.
- Words are copied in ascending index order. For an overlapping region with dst>src, the result is whatever that ordering produces. Callers are responsible for overlap.
- start while busy is ignored. It has no effect on the transfer in progress.
- All registered outputs reset to 0: busy, done, checksum, avm_address, avm_chipselect, avm_write, avm_writedata, avm_byteenable.
- Reset mid-copy returns to IDLE immediately. Words already written stay in the RAM, and no done pulse is produced.
- The checksum holds its value from DONE until the next accepted start.

## Timing
- A start accepted in cycle 0 puts the first READ in cycle 1.
- Each word takes READ_LATENCY+2 cycles: READ, READ_LATENCY×WAIT, then WRITE.
- For word_count N≥1, done is high in cycle 1+N·(READ_LATENCY+2).
- For word_count 0, done is high in cycle 1.
- busy rises in cycle 1 and falls after the DONE cycle. A new start is accepted in the cycle after done.
- avm_chipselect is never high in two consecutive cycles. A read is never issued in the same cycle as a write.

## Configuration
- MULTICORE_RAM_COPY_CHECKSUM_EN defined: in each WRITE cycle, checksum ← checksum + avm_writedata, modulo 2^32.
- Not defined: the checksum port is constant 0 and no adder is synthesized. All other behaviour and timing are identical.

## Test plan
- RAM model preloaded with mem[k]=k+0x100; src=0, dst=512, count=4, READ_LATENCY=1. Required response:
  - mem[512..515] = 0x100..0x103.
  - done in cycle 13.
  - checksum 0x406 (with the macro) or 0 (without).
- count=0: done pulses in cycle 1, avm_chipselect stays 0 throughout, busy is high for cycle 1 only.
- Wrap: src=1022, dst=2, count=3. Writes go to 2, 3, 4 with data from 1022, 1023, 0. Addresses wrap with no error.
- start pulsed again during the 2nd word: ignored. Only the original count of words is written, and done pulses once.
- reset asserted during WAIT of word 2 of 5: all outputs go to 0 asynchronously, mem[dst+0] is written, mem[dst+2..4] are untouched, no done pulse.
- READ_LATENCY=3, count=2: each WRITE follows its READ by 4 cycles, captured data matches the RAM model, and done is in cycle 11.

Source files
------------

// File: rtl/multicore_system_ram_copier_if.sv
// Avalon-MM bus between the RAM copier (master) and a core's on-chip RAM slave port.
interface multicore_system_ram_copier_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/multicore_system_ram_copier.sv
// Word-block copier inside one single-port RAM: one read then one write per word.
// Define MULTICORE_RAM_COPY_CHECKSUM_EN to get a running sum of the copied words.
module multicore_system_ram_copier #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [ADDR_W:0]      word_count,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          checksum,
  multicore_system_ram_copier_if.master avm
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  localparam logic [1:0] LastWait = 2'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   count_q, count_d, idx_q, idx_d;
  logic [1:0]        wait_q, wait_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_q, cs_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]        be_q, be_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    count_d = count_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          count_d = word_count;
          idx_d   = '0;
          state_d = (word_count == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == LastWait) begin
          data_d  = avm.avm_readdata;
          state_d = StWrite;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StWrite: begin
        if ((idx_q + 1'b1) == count_q) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered, so they are decoded from the state being entered.
    cs_d   = (state_d == StRead) || (state_d == StWrite);
    we_d   = (state_d == StWrite);
    be_d   = cs_d ? 4'hF : 4'h0;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    if (state_d == StWrite)     addr_d = dst_d + idx_d[ADDR_W-1:0];
    else if (state_d == StRead) addr_d = src_d + idx_d[ADDR_W-1:0];
    else                        addr_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      be_q    <= be_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MULTICORE_RAM_COPY_CHECKSUM_EN
  logic [31:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state_q == StIdle && start) begin
      sum_q <= '0;
    end else if (state_q == StWrite) begin
      sum_q <= sum_q + data_q;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write      = we_q;
  assign avm.avm_writedata  = data_q;

endmodule

// File: tb/tb_multicore_system_ram_copier.sv
// Bench for the RAM copier: latency-1 and latency-3 instances, each on its own RAM model.
module tb_multicore_system_ram_copier;

`ifdef MULTICORE_RAM_COPY_CHECKSUM_EN
  localparam bit CkEn = 1'b1;
`else
  localparam bit CkEn = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [9:0]  src_addr = '0, dst_addr = '0;
  logic [10:0] word_count = '0;
  logic        busy1, done1, busy3, done3;
  logic [31:0] sum1, sum3;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] exp1 [1024];
  logic [31:0] exp3 [1024];
  logic        mem_ready = 1'b0;
  logic [31:0] rd1, rd3a, rd3b, rd3c;
  wr_t         q1[$];
  wr_t         q3[$];

  multicore_system_ram_copier_if #(.ADDR_W(10)) bus1 ();
  multicore_system_ram_copier_if #(.ADDR_W(10)) bus3 ();

  multicore_system_ram_copier #(.READ_LATENCY(1), .ADDR_W(10)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy1), .done(done1), .checksum(sum1), .avm(bus1)
  );

  multicore_system_ram_copier #(.READ_LATENCY(3), .ADDR_W(10)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy3), .done(done3), .checksum(sum3), .avm(bus3)
  );

  always #5 clk = ~clk;

  // RAM models: latency 1 (registered read) and latency 3 (two extra pipeline stages).
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) begin
        mem1[k] <= 32'h100 + 32'(k);
        mem3[k] <= 32'(k) * 3 + 7;
      end
      mem_ready <= 1'b1;
    end else begin
      if (bus1.avm_chipselect && bus1.avm_write) mem1[bus1.avm_address] <= bus1.avm_writedata;
      if (bus3.avm_chipselect && bus3.avm_write) mem3[bus3.avm_address] <= bus3.avm_writedata;
    end
    rd1  <= mem1[bus1.avm_address];
    rd3a <= mem3[bus3.avm_address];
    rd3b <= rd3a;
    rd3c <= rd3b;
  end

  assign bus1.avm_readdata = rd1;
  assign bus3.avm_readdata = rd3c;

  // Drives one copy starting at cycle 0 and follows it cycle by cycle, popping the scoreboard
  // on every write. restart_at re-pulses start (with altered operands); abort_at asserts reset.
  task automatic run_copy(input int sel, input logic [9:0] s, input logic [9:0] d,
                          input logic [10:0] n, input int restart_at, input int abort_at,
                          output int done_cyc, output int done_pulses, output int busy_cyc,
                          output int cs_cyc, output logic [31:0] done_sum,
                          output logic [31:0] exp_sum);
    wr_t e;
    logic cs, we, bs, dn;
    logic [3:0] be;
    logic [9:0] a;
    logic [31:0] wd, sm;
    int last_rd, want_gap;
    done_cyc = -1; done_pulses = 0; busy_cyc = 0; cs_cyc = 0; done_sum = '0; exp_sum = '0;
    last_rd = -100;
    want_gap = (sel != 0) ? 4 : 2;
    for (int i = 0; i < int'(n); i++) begin
      e.a = d + 10'(i);
      if (sel != 0) begin
        e.d = exp3[s + 10'(i)];
        exp3[e.a] = e.d;
        q3.push_back(e);
      end else begin
        e.d = exp1[s + 10'(i)];
        exp1[e.a] = e.d;
        q1.push_back(e);
      end
      exp_sum += e.d;
    end
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = n;
    if (sel != 0) start3 = 1'b1; else start1 = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      cs = (sel != 0) ? bus3.avm_chipselect : bus1.avm_chipselect;
      we = (sel != 0) ? bus3.avm_write : bus1.avm_write;
      be = (sel != 0) ? bus3.avm_byteenable : bus1.avm_byteenable;
      a  = (sel != 0) ? bus3.avm_address : bus1.avm_address;
      wd = (sel != 0) ? bus3.avm_writedata : bus1.avm_writedata;
      bs = (sel != 0) ? busy3 : busy1;
      dn = (sel != 0) ? done3 : done1;
      sm = (sel != 0) ? sum3 : sum1;
      if (sel != 0) start3 = (c == restart_at); else start1 = (c == restart_at);
      if (c == restart_at) begin
        src_addr = s + 10'd37;
        word_count = 11'd9;
      end
      if (bs) busy_cyc++;
      if (cs) begin
        cs_cyc++;
        n_checks++;
        if (be !== 4'hF) begin
          n_fail++;
          $display("FAIL byteenable c%0d: got %h want f", c, be);
        end
        if (!we) last_rd = c;
      end
      if (cs && we) begin
        n_checks++;
        if ((c - last_rd) !== want_gap) begin
          n_fail++;
          $display("FAIL read_to_write_gap c%0d: got %0d want %0d", c, c - last_rd, want_gap);
        end
        n_checks++;
        if ((sel != 0 && q3.size() == 0) || (sel == 0 && q1.size() == 0)) begin
          n_fail++;
          $display("FAIL unexpected_write c%0d: got addr %0d data %h want none", c, a, wd);
        end else begin
          e = (sel != 0) ? q3.pop_front() : q1.pop_front();
          if (a !== e.a || wd !== e.d) begin
            n_fail++;
            $display("FAIL write_sb c%0d: got %0d/%h want %0d/%h", c, a, wd, e.a, e.d);
          end
        end
      end
      if (dn) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = c;
          done_sum = sm;
        end
      end
      if (c == abort_at) begin
        #1 reset = 1'b1;
        #1;
        break;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy1, done1, sum1, bus1.avm_address, bus1.avm_byteenable, bus1.avm_chipselect,
         bus1.avm_write, bus1.avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs1: got busy %b done %b cs %b addr %0d want all 0",
               busy1, done1, bus1.avm_chipselect, bus1.avm_address);
    end
    n_checks++;
    if ({busy3, done3, sum3, bus3.avm_address, bus3.avm_byteenable, bus3.avm_chipselect,
         bus3.avm_write, bus3.avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs3: got busy %b done %b cs %b want all 0",
               busy3, done3, bus3.avm_chipselect);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, dp, bc, cc;
    logic [31:0] ds, es;
    run_copy(0, 10'd0, 10'd512, 11'd4, -1, -1, dc, dp, bc, cc, ds, es);
    n_checks++;
    if (dc !== 13) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 13", dc); end
    n_checks++;
    if (dp !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", dp); end
    n_checks++;
    if (bc !== 13) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 13", bc); end
    n_checks++;
    if (ds !== (CkEn ? 32'h406 : 32'h0)) begin
      n_fail++;
      $display("FAIL basic_checksum: got %h want %h", ds, CkEn ? 32'h406 : 32'h0);
    end
    n_checks++;
    if (sum1 !== ds) begin
      n_fail++;
      $display("FAIL basic_checksum_hold: got %h want %h", sum1, ds);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem1[512 + k] !== 32'h100 + 32'(k)) begin
        n_fail++;
        $display("FAIL basic_mem[%0d]: got %h want %h", 512 + k, mem1[512 + k], 32'h100 + k);
      end
    end
  endtask

  task automatic test_zero_count();
    int dc, dp, bc, cc;
    logic [31:0] ds, es;
    run_copy(0, 10'd5, 10'd600, 11'd0, -1, -1, dc, dp, bc, cc, ds, es);
    n_checks++;
    if (dc !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
    n_checks++;
    if (bc !== 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d want 1", bc); end
    n_checks++;
    if (cc !== 0) begin n_fail++; $display("FAIL zero_chipselect: got %0d cycles want 0", cc); end
  endtask

  task automatic test_wrap();
    int dc, dp, bc, cc;
    logic [31:0] ds, es;
    logic [31:0] want [3];
    want[0] = 32'h4FE; want[1] = 32'h4FF; want[2] = 32'h100;
    run_copy(0, 10'd1022, 10'd2, 11'd3, -1, -1, dc, dp, bc, cc, ds, es);
    n_checks++;
    if (dc !== 10) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 10", dc); end
    n_checks++;
    if (ds !== (CkEn ? 32'hAFD : 32'h0)) begin
      n_fail++;
      $display("FAIL wrap_checksum: got %h want %h", ds, CkEn ? 32'hAFD : 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (mem1[2 + k] !== want[k]) begin
        n_fail++;
        $display("FAIL wrap_mem[%0d]: got %h want %h", 2 + k, mem1[2 + k], want[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dc, dp, bc, cc;
    logic [31:0] ds, es;
    run_copy(0, 10'd100, 10'd700, 11'd5, 4, -1, dc, dp, bc, cc, ds, es);
    n_checks++;
    if (dc !== 16) begin n_fail++; $display("FAIL restart_done_cycle: got %0d want 16", dc); end
    n_checks++;
    if (dp !== 1) begin n_fail++; $display("FAIL restart_done_pulses: got %0d want 1", dp); end
    n_checks++;
    if (q1.size() !== 0) begin
      n_fail++;
      $display("FAIL restart_pending_writes: got %0d want 0", q1.size());
    end
    n_checks++;
    if (mem1[705] !== 32'h100 + 32'd705) begin
      n_fail++;
      $display("FAIL restart_extra_word: got %h want %h", mem1[705], 32'h100 + 705);
    end
    n_checks++;
    if (ds !== (CkEn ? es : 32'h0)) begin
      n_fail++;
      $display("FAIL restart_checksum: got %h want %h", ds, CkEn ? es : 32'h0);
    end
  endtask

  task automatic test_reset_mid_copy();
    int dc, dp, bc, cc, late_done;
    logic [31:0] ds, es;
    // Cycle 5 is the WAIT of the second word with latency 1.
    run_copy(0, 10'd200, 10'd800, 11'd5, -1, 5, dc, dp, bc, cc, ds, es);
    n_checks++;
    if ({busy1, done1, sum1, bus1.avm_address, bus1.avm_byteenable, bus1.avm_chipselect,
         bus1.avm_write, bus1.avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy %b cs %b wd %h want all 0",
               busy1, bus1.avm_chipselect, bus1.avm_writedata);
    end
    @(negedge clk);
    reset = 1'b0;
    late_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done1 || busy1) late_done++;
    end
    n_checks++;
    if (dp + late_done !== 0) begin
      n_fail++;
      $display("FAIL abort_done_or_busy: got %0d cycles want 0", dp + late_done);
    end
    n_checks++;
    if (q1.size() !== 4) begin
      n_fail++;
      $display("FAIL abort_writes_left: got %0d want 4", q1.size());
    end
    n_checks++;
    if (mem1[800] !== 32'h1C8) begin
      n_fail++;
      $display("FAIL abort_mem[800]: got %h want 1c8", mem1[800]);
    end
    for (int k = 2; k < 5; k++) begin
      n_checks++;
      if (mem1[800 + k] !== 32'h100 + 32'(800 + k)) begin
        n_fail++;
        $display("FAIL abort_mem[%0d]: got %h want %h", 800 + k, mem1[800 + k], 32'h100 + 800 + k);
      end
    end
    q1.delete();
    for (int k = 1; k < 5; k++) exp1[800 + k] = 32'h100 + 32'(800 + k);
  endtask

  task automatic test_latency3();
    int dc, dp, bc, cc;
    logic [31:0] ds, es;
    run_copy(1, 10'd10, 10'd20, 11'd2, -1, -1, dc, dp, bc, cc, ds, es);
    n_checks++;
    if (dc !== 11) begin n_fail++; $display("FAIL lat3_done_cycle: got %0d want 11", dc); end
    n_checks++;
    if (ds !== (CkEn ? 32'd77 : 32'h0)) begin
      n_fail++;
      $display("FAIL lat3_checksum: got %h want %h", ds, CkEn ? 32'd77 : 32'h0);
    end
    n_checks++;
    if (mem3[20] !== 32'd37 || mem3[21] !== 32'd40) begin
      n_fail++;
      $display("FAIL lat3_mem: got %0d,%0d want 37,40", mem3[20], mem3[21]);
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      exp1[k] = 32'h100 + 32'(k);
      exp3[k] = 32'(k) * 3 + 7;
    end
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_copy();
    test_latency3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
